// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared 256-word RAM.
// Port 0 is instruction fetch and port 1 is load/store. Each granted request is
// latched, then run through SETUP -> ACCESS -> RELEASE so that the read and write
// strobes are never high together. Read data is captured into a register per port.
module ram_arbiter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [8:0]  addr0,
  input  logic [8:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        done0,
  output logic        done1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic [8:0]  mem_addr,
  inout  wire  [31:0] mem_data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RELEASE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES - 1);

  state_t      state_q, state_d;
  logic        turn_q, turn_d;          // bus turnaround: first IDLE cycle after RELEASE
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;          // port owning the current transaction
  logic        we_q, we_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        data_oe_q, data_oe_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [8:0]  mem_addr_q, mem_addr_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        err0_q, err0_d;
  logic        err1_q, err1_d;
  logic        busy_q, busy_d;

  logic        grant_sel;
  logic        sel_we;
  logic [8:0]  sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;

  // Round-robin choice: on a tie the port that did not win last time goes next.
  assign grant_sel = (req0 && req1) ? ~last_grant_q : req1;
  assign sel_we    = grant_sel ? we1    : we0;
  assign sel_addr  = grant_sel ? addr1  : addr0;
  assign sel_wdata = grant_sel ? wdata1 : wdata0;
  assign in_range  = ~addr_q[8];

  // Next-state, latching and output decode for the access sequencer.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    turn_d       = turn_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    data_oe_d    = data_oe_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err0_d       = 1'b0;
    err1_d       = 1'b0;
    busy_d       = busy_q;

    case (state_q)
      IDLE: begin
        // One dead IDLE cycle after RELEASE lets the data bus turn around and
        // gives the 3+ACCESS_CYCLES+1 back-to-back period.
        turn_d = 1'b0;
        if (!turn_q && (req0 || req1)) begin
          state_d      = SETUP;
          busy_d       = 1'b1;
          last_grant_d = grant_sel;
          port_d       = grant_sel;
          we_d         = sel_we;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          mem_addr_d   = sel_addr;
          // Out-of-range writes never strobe, so they never drive the bus either.
          data_oe_d    = sel_we & ~sel_addr[8];
        end
      end
      SETUP: begin
        state_d     = ACCESS;
        cnt_d       = CNT_INIT;
        mem_read_d  = ~we_q & in_range;
        mem_write_d = we_q & in_range;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          // Last strobe edge: finish, report, and capture the bus for reads.
          state_d = RELEASE;
          if (port_q) begin
            done1_d = 1'b1;
            err1_d  = addr_q[8];
            if (!we_q) rdata1_d = in_range ? mem_data : 32'd0;
          end else begin
            done0_d = 1'b1;
            err0_d  = addr_q[8];
            if (!we_q) rdata0_d = in_range ? mem_data : 32'd0;
          end
        end else begin
          cnt_d       = cnt_q - 4'd1;
          mem_read_d  = ~we_q & in_range;
          mem_write_d = we_q & in_range;
        end
      end
      RELEASE: begin
        state_d    = IDLE;
        turn_d     = 1'b1;
        busy_d     = 1'b0;
        mem_addr_d = 9'd0;
        data_oe_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      turn_q       <= 1'b0;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= 9'd0;
      wdata_q      <= 32'd0;
      cnt_q        <= 4'd0;
      data_oe_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 9'd0;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err0_q       <= 1'b0;
      err1_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      turn_q       <= turn_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      data_oe_q    <= data_oe_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err0_q       <= err0_d;
      err1_q       <= err1_d;
      busy_q       <= busy_d;
    end
  end

  assign mem_data  = data_oe_q ? wdata_q : 32'bz;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign busy      = busy_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer for the shared 32-bit word RAM. It gives the instruction-fetch side (port 0) and the load/store side (port 1) exclusive, round-robin access to the RAM's single read/write strobe pair and bidirectional data bus. It latches each request, sequences setup, strobe and release phases so `read` and `write` are never asserted together, and captures read data.

## Interface
- `ACCESS_CYCLES`, default 2: number of cycles the read/write strobe is held; legal range 1–15.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  request level per port; held high until `doneN` is sampled.
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled at grant.
- `addr0`, `addr1`  in  9  word address; sampled at grant.
- `wdata0`, `wdata1`  in  32  write data; sampled at grant.
- `rdata0`, `rdata1`  out  32  captured read data, registered per port.
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `err0`, `err1`  out  1  one-cycle pulse alongside `doneN` when the address is out of range.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `mem_read`  out  1  RAM read strobe.
- `mem_write`  out  1  RAM write strobe.
- `mem_addr`  out  9  RAM address.
- `mem_data`  inout  32  RAM data bus; driven only during a granted write, otherwise high-Z.

## Operation
- **FSM states:**
  - IDLE → SETUP on any `reqN`.
  - SETUP → ACCESS after 1 cycle.
  - ACCESS → RELEASE after `ACCESS_CYCLES` cycles.
  - RELEASE → IDLE after 1 cycle.
- **Arbitration in IDLE:**
  - If only one port requests, that port is granted.
  - If both request, grant the port not granted last; `last_grant` is a 1-bit register.
  - `last_grant` updates on every grant.
- **Latching at grant:** `we`, `addr` and `wdata` of the granted port go into internal registers. Changes on the requester inputs after the grant have no effect.
- **Bus driving during a transaction:**
  - SETUP: `mem_addr` = latched address, strobes 0. For a write, `mem_data` = latched `wdata`.
  - ACCESS: `mem_read` = !we or `mem_write` = we; address and data held stable.
  - RELEASE: strobes 0; address and data held one more cycle.
  - `doneN` = 1 for the granted port only.
- **Read capture:** on the last ACCESS edge, `mem_data` is registered into `rdataN`. `rdataN` holds until the next read on that port; writes and errors on the other port do not disturb it.
- **Address range:** the RAM holds 256 words. If `addr[8]` = 1:
  - no strobe is asserted in ACCESS;
  - `errN` pulses with `doneN`;
  - `rdataN` is loaded with 0 for a read.
- **Outside transactions:** in IDLE, `mem_addr` = 0, strobes = 0, `mem_data` = Z.
- **Requester handshake:** the requester deasserts `reqN` at the edge where it samples `doneN` = 1. A `req` still high in IDLE starts a new transaction.
- **Early request drop:** dropping `reqN` before done does not abort. The transaction completes and `doneN` still pulses.
- **Invariants:**
  - `mem_read & mem_write` is never 1.
  - `mem_data` is driven only while `mem_write` can be asserted (SETUP through RELEASE of a write).
- **Reset (asynchronous):**
  - FSM returns to IDLE.
  - All outputs go to 0, including `rdata0`, `rdata1`, `done*`, `err*`, `busy` and the strobes; `mem_data` goes to Z.
  - `last_grant` = 1, so port 0 wins the first tie.
  - A transaction in flight is dropped without `done`.

## Timing
- `reqN` high in IDLE cycle t: SETUP at t+1, ACCESS t+2 … t+1+`ACCESS_CYCLES`, RELEASE at t+2+`ACCESS_CYCLES`.
- `doneN` is high in cycle t+2+`ACCESS_CYCLES` only; `rdataN` is valid from that cycle.
- Occupancy is 3+`ACCESS_CYCLES` cycles per transaction plus 1 IDLE cycle. With `ACCESS_CYCLES` = 2, the back-to-back period is 6 cycles.
- `busy` rises the cycle after a grant decision and falls on the RELEASE→IDLE edge.
- Both ports requesting continuously alternate 0,1,0,1 after reset.

## Test plan
- **Reset:** RAM word 85 = 0x00000002; assert `reset` mid-ACCESS → strobes drop to 0 immediately, no `done`, all outputs 0; after release, `req0` read at 85 → `done0` at t+4, `rdata0` = 0x00000002.
- **Write then read:** port 1 writes 0x1080005A to address 90, then port 0 reads 90 → `rdata0` = 0x1080005A. `mem_write` is high exactly 2 cycles, and `mem_data` is Z before SETUP and after RELEASE.
- **Contention:** `req0` and `req1` rise in the same cycle, held → grants port 0, 1, 0, 1. `done0` and `done1` are never in the same cycle and are 6 cycles apart.
- **Out of range:** port 0 reads address 0x100 → `mem_read` stays 0, `err0` and `done0` pulse together, `rdata0` = 0.
- **Input isolation:** change `addr1`/`wdata1` one cycle after the grant → the RAM receives the originally latched values.
- **Parameter sweep:** `ACCESS_CYCLES` = 1 and 15 → latency from request to `done` is 3 and 17 cycles respectively. A `read && write` assertion on the bus never fires.
